reg_file_writeback_stage: RTL and testbench

//  MEM/WB pipeline register and write-back datapath for the pd3 MIPS core.

---
 rtl/pd3_wb_pkg.sv | 23 ++
 rtl/wb_load_align.sv | 51 +++++
 rtl/reg_file_writeback_stage.sv | 127 ++++++++++++
 tb/tb_reg_file_writeback_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pd3_wb_pkg.sv
// Shared constants and encodings for the pd3 MEM/WB write-back stage.
package pd3_wb_pkg;

  // Default datapath and register-address widths.
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Write-back data source selection.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_LINK = 2'b10,
    RES_RSVD = 2'b11
  } res_sel_e;

  // Load access size; 2'b11 is unused and behaves like a word.
  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10
  } ld_size_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational subword load extraction and sign/zero extension.
// Lanes are big-endian: byte offset 0 selects the most significant byte.
// Only built when WB_SUBWORD_LOAD_EN is defined; otherwise the
// write-back stage passes the raw memory word straight through.
`ifdef WB_SUBWORD_LOAD_EN
module wb_load_align #(
  parameter int DATA_W = pd3_wb_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_off,
  output logic [DATA_W-1:0] o_data
);
  import pd3_wb_pkg::*;

  logic [DATA_W-1:0] w_byte_shift;
  logic [DATA_W-1:0] w_half_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Move the addressed lane to the top, then extend it to full width.
  // A misaligned half ignores off[0] and uses the lane at off & 2'b10.
  always_comb begin
    w_byte_shift = i_data << {i_off, 3'b000};
    w_half_shift = i_data << {i_off[1], 4'b0000};
    w_byte       = w_byte_shift[DATA_W-1 -: 8];
    w_half       = w_half_shift[DATA_W-1 -: 16];
    o_data       = i_data;
    case (i_size)
      LD_BYTE: begin
        if (i_unsigned) begin
          o_data = {{(DATA_W-8){1'b0}}, w_byte};
        end else begin
          o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
        end
      end
      LD_HALF: begin
        if (i_unsigned) begin
          o_data = {{(DATA_W-16){1'b0}}, w_half};
        end else begin
          o_data = {{(DATA_W-16){w_half[15]}}, w_half};
        end
      end
      LD_WORD: o_data = i_data;
      default: o_data = i_data;
    endcase
  end

endmodule
`endif

// File: rtl/reg_file_writeback_stage.sv
// MEM/WB pipeline register and write-back datapath for the pd3 MIPS core.
// Selects destination register and write-back data, drives the register
// file write port one cycle later, and counts retired register writes.
// Optional feature macro: WB_SUBWORD_LOAD_EN (subword load alignment).
module reg_file_writeback_stage #(
  parameter int DATA_W = pd3_wb_pkg::DATA_W,
  parameter int ADDR_W = pd3_wb_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid_in,
  input  logic              w_stall,
  input  logic              w_flush,
  input  logic              w_en_in,
  input  logic              w_waddr_sel,
  input  logic [ADDR_W-1:0] w_rt_in,
  input  logic [ADDR_W-1:0] w_rd_in,
  input  logic [1:0]        w_result_sel,
  input  logic [DATA_W-1:0] w_alu_result,
  input  logic [DATA_W-1:0] w_load_data,
  input  logic [DATA_W-1:0] w_pc_in,
  input  logic [1:0]        w_load_size,
  input  logic              w_load_unsigned,
  input  logic [1:0]        w_byte_off,
  output logic              w_rf_wen,
  output logic [ADDR_W-1:0] w_rf_waddr,
  output logic [DATA_W-1:0] w_rf_wdata,
  output logic              w_wb_valid,
  output logic [CNT_W-1:0]  w_retire_count
);
  import pd3_wb_pkg::*;

  logic [DATA_W-1:0] w_load_word;
  logic [ADDR_W-1:0] w_next_waddr;
  logic [DATA_W-1:0] w_next_wdata;
  logic              w_next_wen;

  logic              r_valid;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_retire_count;

`ifdef WB_SUBWORD_LOAD_EN
  wb_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .i_data    (w_load_data),
    .i_size    (w_load_size),
    .i_unsigned(w_load_unsigned),
    .i_off     (w_byte_off),
    .o_data    (w_load_word)
  );
`else
  // Subword controls have no effect in this build; the raw word is used.
  logic w_unused_load_ctl;
  assign w_unused_load_ctl = ^{w_load_size, w_load_unsigned, w_byte_off};
  assign w_load_word       = w_load_data;
`endif

  // Destination select: the mux is gated by w_en_in so an undriven
  // w_waddr_sel on non-writing instructions can never reach the port.
  always_comb begin
    w_next_waddr = {ADDR_W{1'b0}};
    if (w_en_in) begin
      if (w_waddr_sel) begin
        w_next_waddr = w_rt_in;
      end else begin
        w_next_waddr = w_rd_in;
      end
    end else begin
      w_next_waddr = {ADDR_W{1'b0}};
    end
  end

  // Write-back data source and write enable; r0 and the reserved
  // result encoding never produce a register-file write.
  always_comb begin
    w_next_wdata = {DATA_W{1'b0}};
    case (w_result_sel)
      RES_ALU:  w_next_wdata = w_alu_result;
      RES_LOAD: w_next_wdata = w_load_word;
      RES_LINK: w_next_wdata = w_pc_in + {{(DATA_W-4){1'b0}}, 4'd8};
      RES_RSVD: w_next_wdata = {DATA_W{1'b0}};
      default:  w_next_wdata = {DATA_W{1'b0}};
    endcase
    if ((w_result_sel != RES_RSVD) && (w_next_waddr != {ADDR_W{1'b0}})) begin
      w_next_wen = w_valid_in & w_en_in;
    end else begin
      w_next_wen = 1'b0;
    end
  end

  // Pipeline register with flush > stall > capture priority. The retire
  // counter steps once when a writing instruction is captured, so a
  // stalled write is counted on its first presentation only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= 1'b0;
      r_wen          <= 1'b0;
      r_waddr        <= {ADDR_W{1'b0}};
      r_wdata        <= {DATA_W{1'b0}};
      r_retire_count <= {CNT_W{1'b0}};
    end else if (w_flush) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
    end else if (!w_stall) begin
      r_valid <= w_valid_in;
      r_wen   <= w_next_wen;
      r_waddr <= w_next_waddr;
      r_wdata <= w_next_wdata;
      if (w_next_wen) begin
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign w_rf_wen       = r_wen;
  assign w_rf_waddr     = r_waddr;
  assign w_rf_wdata     = r_wdata;
  assign w_wb_valid     = r_valid;
  assign w_retire_count = r_retire_count;

endmodule

// File: tb/tb_reg_file_writeback_stage.sv
// Self-checking bench for reg_file_writeback_stage: directed vectors, a
// behavioural model compared every cycle, and literal expectations.
module tb_reg_file_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_valid_in, w_stall, w_flush, w_en_in, w_waddr_sel;
  logic [4:0]  w_rt_in, w_rd_in;
  logic [1:0]  w_result_sel, w_load_size, w_byte_off;
  logic [31:0] w_alu_result, w_load_data, w_pc_in;
  logic        w_load_unsigned;
  logic        w_rf_wen, w_wb_valid;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata, w_retire_count;

  always #5 clock = ~clock;

  reg_file_writeback_stage dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid_in(w_valid_in), .w_stall(w_stall), .w_flush(w_flush),
    .w_en_in(w_en_in), .w_waddr_sel(w_waddr_sel),
    .w_rt_in(w_rt_in), .w_rd_in(w_rd_in), .w_result_sel(w_result_sel),
    .w_alu_result(w_alu_result), .w_load_data(w_load_data), .w_pc_in(w_pc_in),
    .w_load_size(w_load_size), .w_load_unsigned(w_load_unsigned),
    .w_byte_off(w_byte_off),
    .w_rf_wen(w_rf_wen), .w_rf_waddr(w_rf_waddr), .w_rf_wdata(w_rf_wdata),
    .w_wb_valid(w_wb_valid), .w_retire_count(w_retire_count)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [1:0] size,
                                          input logic uns, input logic [1:0] off);
    logic [31:0] v;
    int          lane;
    v = d;
`ifdef WB_SUBWORD_LOAD_EN
    if (size == 2'd2) begin
      v = (d >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      lane = int'(off) & 2;
      v = (d >> (8 * (2 - lane))) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
`endif
    return v;
  endfunction

  function automatic logic [4:0] exp_addr(input logic en, input logic sel,
                                          input logic [4:0] rt, input logic [4:0] rd);
    if (!en) return 5'd0;
    return (sel === 1'b1) ? rt : rd;
  endfunction

  function automatic logic [31:0] exp_data(input logic [1:0] res);
    case (res)
      2'd0:    return w_alu_result;
      2'd1:    return exp_load(w_load_data, w_load_size, w_load_unsigned, w_byte_off);
      2'd2:    return w_pc_in + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  logic        m_valid, m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_count;

  // Model of the stage's architectural state.
  always @(posedge clock or negedge reset_n) begin
    logic [4:0] a;
    logic       we;
    if (!reset_n) begin
      m_valid <= 1'b0; m_wen <= 1'b0; m_waddr <= 5'd0; m_wdata <= 32'd0; m_count <= 32'd0;
    end else if (w_flush) begin
      m_valid <= 1'b0; m_wen <= 1'b0; m_waddr <= 5'd0; m_wdata <= 32'd0;
    end else if (!w_stall) begin
      a  = exp_addr(w_en_in, w_waddr_sel, w_rt_in, w_rd_in);
      we = w_valid_in && w_en_in && (a != 5'd0) && (w_result_sel != 2'd3);
      m_valid <= w_valid_in;
      m_wen   <= we;
      m_waddr <= a;
      m_wdata <= exp_data(w_result_sel);
      if (we) m_count <= m_count + 32'd1;
    end
  end

  // Per-cycle comparison away from the rising edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("wen",   32'(w_rf_wen),   32'(m_wen));
      check("waddr", 32'(w_rf_waddr), 32'(m_waddr));
      check("wdata", w_rf_wdata,      m_wdata);
      check("valid", 32'(w_wb_valid), 32'(m_valid));
      check("count", w_retire_count,  m_count);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic instr(input logic v, input logic en, input logic sel,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] res,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                       input logic [1:0] size, input logic uns, input logic [1:0] off);
    w_valid_in = v; w_en_in = en; w_waddr_sel = sel; w_rt_in = rt; w_rd_in = rd;
    w_result_sel = res; w_alu_result = alu; w_load_data = ld; w_pc_in = pc;
    w_load_size = size; w_load_unsigned = uns; w_byte_off = off;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_lb_s, exp_lb_u;

  initial begin
`ifdef WB_SUBWORD_LOAD_EN
    exp_lb_s = 32'hFFFF_FF80;
    exp_lb_u = 32'h0000_0080;
`else
    exp_lb_s = 32'h80FF_0000;
    exp_lb_u = 32'h80FF_0000;
`endif
    reset_n = 1'b0; w_stall = 1'b0; w_flush = 1'b0;
    instr(1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 2'd0, 32'h1111, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    #1;
    // Reset is asynchronous: outputs are zero before any clock edge.
    check("rst_wen",   32'(w_rf_wen),   32'd0);
    check("rst_valid", 32'(w_wb_valid), 32'd0);
    check("rst_count", w_retire_count,  32'd0);
    step(); step();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Plain ALU write to rd=7.
    instr(1'b1, 1'b1, 1'b0, 5'd2, 5'd7, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    check("t2_wen",   32'(w_rf_wen),   32'd1);
    check("t2_waddr", 32'(w_rf_waddr), 32'd7);
    check("t2_wdata", w_rf_wdata,      32'h0000_1234);
    check("t2_count", w_retire_count,  32'd1);

    // rt selected and rt=0: write suppressed.
    instr(1'b1, 1'b1, 1'b1, 5'd0, 5'd9, 2'd0, 32'h0000_5678, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    check("t3_wen",   32'(w_rf_wen),   32'd0);
    check("t3_count", w_retire_count,  32'd1);

    // Link to r31.
    instr(1'b1, 1'b1, 1'b0, 5'd1, 5'd31, 2'd2, 32'd0, 32'd0, 32'h0040_0010, 2'd0, 1'b0, 2'd0);
    step();
    check("t4_waddr", 32'(w_rf_waddr), 32'd31);
    check("t4_wdata", w_rf_wdata,      32'h0040_0018);
    check("t4_count", w_retire_count,  32'd2);

    // Capture a write, then stall three cycles with new inputs waiting.
    instr(1'b1, 1'b1, 1'b0, 5'd1, 5'd5, 2'd0, 32'h0000_AAAA, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    w_stall = 1'b1;
    instr(1'b1, 1'b1, 1'b0, 5'd1, 5'd6, 2'd0, 32'h0000_5555, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) step();
    check("t5_wen",   32'(w_rf_wen),   32'd1);
    check("t5_waddr", 32'(w_rf_waddr), 32'd5);
    check("t5_wdata", w_rf_wdata,      32'h0000_AAAA);
    check("t5_count", w_retire_count,  32'd3);
    // Flush wins over stall.
    w_flush = 1'b1;
    step();
    check("t5_fl_wen",   32'(w_rf_wen),   32'd0);
    check("t5_fl_valid", 32'(w_wb_valid), 32'd0);
    check("t5_fl_count", w_retire_count,  32'd3);
    w_flush = 1'b0; w_stall = 1'b0;

    // Byte load at offset 0, signed then unsigned.
    instr(1'b1, 1'b1, 1'b0, 5'd1, 5'd9, 2'd1, 32'd0, 32'h80FF_0000, 32'd0, 2'd2, 1'b0, 2'd0);
    step();
    check("t6_lb_s", w_rf_wdata, exp_lb_s);
    instr(1'b1, 1'b1, 1'b0, 5'd1, 5'd9, 2'd1, 32'd0, 32'h80FF_0000, 32'd0, 2'd2, 1'b1, 2'd0);
    step();
    check("t6_lb_u", w_rf_wdata, exp_lb_u);
    check("t6_count", w_retire_count, 32'd5);

    // Further vectors checked against the model only.
    instr(1'b1, 1'b1, 1'b1, 5'd4, 5'd1, 2'd1, 32'd0, 32'h1234_8001, 32'd0, 2'd1, 1'b0, 2'd2);
    step();
    instr(1'b1, 1'b1, 1'b1, 5'd4, 5'd1, 2'd1, 32'd0, 32'h1234_8001, 32'd0, 2'd1, 1'b1, 2'd3);
    step();
    instr(1'b1, 1'b1, 1'b0, 5'd4, 5'd8, 2'd1, 32'd0, 32'h00C3_7F11, 32'd0, 2'd2, 1'b0, 2'd3);
    step();
    instr(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 2'd3, 32'h0000_9999, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    check("rsvd_wen", 32'(w_rf_wen), 32'd0);
    instr(1'b1, 1'b0, 1'bx, 5'd4, 5'd3, 2'd0, 32'h0000_7777, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    check("nowr_waddr", 32'(w_rf_waddr), 32'd0);
    instr(1'b0, 1'b1, 1'b0, 5'd4, 5'd4, 2'd0, 32'h0000_6666, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    instr(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 2'd0, 32'h0000_6666, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    instr(1'b1, 1'b1, 1'b1, 5'd17, 5'd0, 2'd2, 32'd0, 32'd0, 32'hFFFF_FFFC, 2'd0, 1'b0, 2'd0);
    step();
    check("wrap_wdata", w_rf_wdata, 32'h0000_0004);
    w_flush = 1'b1;
    instr(1'b1, 1'b1, 1'b0, 5'd4, 5'd12, 2'd0, 32'h0000_3333, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    w_flush = 1'b0;
    // Stall released onto a new write: counts once more.
    w_stall = 1'b1;
    step();
    w_stall = 1'b0;
    instr(1'b1, 1'b1, 1'b0, 5'd4, 5'd12, 2'd0, 32'h0000_BEEF, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    check("pre_rst_wen", 32'(w_rf_wen), 32'd1);

    // Asynchronous reset mid-operation while a write is presented.
    reset_n = 1'b0;
    #1;
    check("mid_rst_wen",   32'(w_rf_wen),   32'd0);
    check("mid_rst_waddr", 32'(w_rf_waddr), 32'd0);
    check("mid_rst_wdata", w_rf_wdata,      32'd0);
    check("mid_rst_valid", 32'(w_wb_valid), 32'd0);
    check("mid_rst_count", w_retire_count,  32'd0);
    step();
    reset_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
